// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the pipelined instruction memory
package imem_pkg;

    // Bounds on the response pipeline depth
    localparam int IMEM_LAT_MIN = 1;
    localparam int IMEM_LAT_MAX = 4;

    // Bit positions inside resp_err
    localparam int IMEM_ERR_MISALIGN = 0;
    localparam int IMEM_ERR_RANGE    = 1;
    localparam int IMEM_ERR_W        = 2;

    // Boot image written to words 0..IMEM_BOOT_LEN-1 after reset (preload builds only)
    localparam int IMEM_BOOT_LEN = 6;
    localparam logic [IMEM_BOOT_LEN-1:0][31:0] IMEM_BOOT_IMAGE = {
        32'h016C0000,
        32'h012A1800,
        32'h00E81000,
        32'h00A60000,
        32'h00640000,
        32'h00220000
    };

endpackage

// File: rtl/imem_resp_pipe.sv
// rtl/imem_resp_pipe.sv - valid-tagged shift pipeline with common stall and flush
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   advance              shift every stage by one when high, freeze all when low
//   flush                clear every stage valid at the next edge
//   in_valid, in_data    entry into stage 0
//   out_valid, out_data  last stage
module imem_resp_pipe #(
    parameter int LATENCY = 1,
    parameter int W       = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [W-1:0]       data_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // Flush only kills the tags; data stages may keep shifting harmlessly
            if (flush) begin
                valid_q <= '0;
            end else if (advance) begin
                valid_q[0] <= in_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
            if (advance) begin
                data_q[0] <= in_data;
                for (int i = 1; i < LATENCY; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_pipelined.sv
// rtl/instr_mem_pipelined.sv - pipelined instruction memory with load port and boot preload
//
// Ports:
//   clk, rst                              clock, asynchronous active-low reset
//   req_valid, req_ready, req_pc          fetch request (byte address)
//   resp_valid, resp_ready                fetch response handshake
//   resp_instr, resp_err                  instruction word and {range, misalign} flags
//   flush                                 drop everything in flight, block accept this cycle
//   load_en, load_addr, load_data         word write port for program download
//   boot_busy                             boot image being written
// Build option: IMEM_BOOT_PRELOAD_EN adds a BOOT state that writes the boot image after reset.
module instr_mem_pipelined
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 48,
    parameter int LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_pc,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [1:0]                     resp_err,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           boot_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Out-of-range depths are clamped rather than producing a broken pipe
    localparam int PIPE_LAT = (LATENCY < IMEM_LAT_MIN) ? IMEM_LAT_MIN :
                              (LATENCY > IMEM_LAT_MAX) ? IMEM_LAT_MAX : LATENCY;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state;
    logic [2:0]             boot_cnt;
    logic [31:0]            mem [DEPTH_WORDS];
    logic                   advance;
    logic                   accept;
    logic                   load_in_range;
    logic [IMEM_ERR_W-1:0]  req_err;
    logic [31:0]            rd_word;
    logic [33:0]            pipe_out;

`ifdef IMEM_BOOT_PRELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
        end else if (state == ST_BOOT) begin
            if (boot_cnt == 3'(IMEM_BOOT_LEN - 1)) begin
                state <= ST_RUN;
            end else begin
                boot_cnt <= boot_cnt + 3'd1;
            end
        end
    end
`else
    assign state    = ST_RUN;
    assign boot_cnt = '0;
`endif

    assign boot_busy = (state == ST_BOOT);

    // A stalled response freezes the whole pipe, so nothing new may enter
    assign advance   = !(resp_valid && !resp_ready);
    assign req_ready = advance && !flush && (state == ST_RUN);
    assign accept    = req_valid && req_ready;

    assign load_in_range = (32'(load_addr) < DEPTH_WORDS);

    // Array has no reset so that contents survive a mid-operation reset
    always_ff @(posedge clk) begin
        if (state == ST_BOOT) begin
            if (32'(boot_cnt) < DEPTH_WORDS) begin
                mem[AW'(boot_cnt)] <= IMEM_BOOT_IMAGE[boot_cnt];
            end
        end else if (load_en && load_in_range) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        req_err                    = '0;
        req_err[IMEM_ERR_MISALIGN] = (req_pc[1:0] != 2'b00);
        req_err[IMEM_ERR_RANGE]    = (64'(req_pc >> 2) >= 64'(DEPTH_WORDS));
    end

    // Read happens in the accept cycle, before any same-cycle load lands
    assign rd_word = (req_err != '0) ? 32'h0 : mem[req_pc[AW+1:2]];

    imem_resp_pipe #(
        .LATENCY (PIPE_LAT),
        .W       (34)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst),
        .advance   (advance),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   ({req_err, rd_word}),
        .out_valid (resp_valid),
        .out_data  (pipe_out)
    );

    assign resp_err   = pipe_out[33:32];
    assign resp_instr = pipe_out[31:0];

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// tb/tb_instr_mem_pipelined.sv - self-checking bench for instr_mem_pipelined
module tb_instr_mem_pipelined;

    localparam int DEPTH = 48;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_instr;
    logic [1:0]  resp_err;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        boot_busy;

    always #5 clk = ~clk;

    instr_mem_pipelined #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
        .resp_err(resp_err), .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .boot_busy(boot_busy)
    );

    typedef struct packed { logic [31:0] instr; logic [1:0] err; } resp_t;
    typedef struct { string name; logic [31:0] pc; logic [31:0] instr; logic [1:0] err; } vec_t;

    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    hs_first = -1;
    int    hs_last = -1;
    bit    run_mode = 1'b0;
    bit    last_accept = 1'b0;
    logic [31:0] ref_mem [DEPTH];
    resp_t exp_q [$];
    logic [31:0] boot_img [6] = '{32'h00220000, 32'h00640000, 32'h00A60000,
                                  32'h00E81000, 32'h012A1800, 32'h016C0000};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic resp_t predict(logic [31:0] pc);
        resp_t r;
        r.err[0] = (pc % 4) != 0;
        r.err[1] = (pc / 4) >= DEPTH;
        if (r.err != 2'b00) r.instr = 32'h0;
        else                r.instr = ref_mem[pc / 4];
        return r;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1
    task automatic step();
        resp_t r;
        @(negedge clk);
        check("req_ready_rule", req_ready,
              (!(resp_valid && !resp_ready) && !flush && run_mode) ? 1 : 0);
        if (resp_valid && resp_ready) begin
            hs_count++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            check("sb_expected_resp", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("sb_instr", resp_instr, r.instr);
                check("sb_err", resp_err, r.err);
            end
        end
        if (flush) exp_q.delete();
        last_accept = req_valid && req_ready;
        if (last_accept) exp_q.push_back(predict(req_pc));
        if (load_en && run_mode && load_addr < DEPTH) ref_mem[load_addr] = load_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_boot();
`ifdef IMEM_BOOT_PRELOAD_EN
        int n = 0;
        run_mode = 1'b0;
        while (boot_busy && n < 20) begin
            n++;
            step();
        end
        check("boot_busy_cycles", n, 6);
        for (int i = 0; i < 6; i++) ref_mem[i] = boot_img[i];
`else
        check("boot_busy_tied_low", boot_busy, 0);
`endif
        run_mode = 1'b1;
    endtask

    task automatic fetch_check(string name, logic [31:0] pc, logic [31:0] ei, logic [1:0] ee,
                               logic le = 1'b0, logic [5:0] la = '0, logic [31:0] ld = '0);
        int k;
        req_valid = 1'b1; req_pc = pc; resp_ready = 1'b1;
        load_en = le; load_addr = la; load_data = ld;
        #1;
        check({name, "_accept"}, req_ready, 1);
        step();
        req_valid = 1'b0; load_en = 1'b0;
        k = 0;
        while (!resp_valid && k < 10) begin
            step();
            k++;
        end
        check({name, "_latency"}, k, LAT - 1);
        check({name, "_instr"}, resp_instr, ei);
        check({name, "_err"}, resp_err, ee);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int hs0, issued, acc_cyc;
        logic [31:0] held, pc;

        vecs[0] = '{"w0",        32'd0,        32'hC0DE0000, 2'b00};
        vecs[1] = '{"w5",        32'd20,       32'hC0DE0005, 2'b00};
        vecs[2] = '{"w_last",    32'd188,      32'hC0DE002F, 2'b00};
        vecs[3] = '{"mis_6",     32'h6,        32'h0,        2'b01};
        vecs[4] = '{"mis_1",     32'h1,        32'h0,        2'b01};
        vecs[5] = '{"range",     32'd192,      32'h0,        2'b10};
        vecs[6] = '{"range_mis", 32'd194,      32'h0,        2'b11};
        vecs[7] = '{"range_top", 32'hFFFFFFFC, 32'h0,        2'b10};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_instr", resp_instr, 0);
        check("rst_resp_err", resp_err, 0);
        rst = 1'b1;
        #1;
`ifdef IMEM_BOOT_PRELOAD_EN
        check("rst_req_ready_boot", req_ready, 0);
        check("rst_boot_busy", boot_busy, 1);
`else
        check("rst_req_ready_run", req_ready, 1);
`endif
        wait_boot();

`ifdef IMEM_BOOT_PRELOAD_EN
        for (int i = 0; i < 6; i++) fetch_check("boot_word", 32'(4 * i), boot_img[i], 2'b00);
`endif

        // Program download, plus a write beyond the array that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = 6'(i); load_data = 32'hC0DE0000 | 32'(i);
            step();
        end
        load_addr = 6'd50; load_data = 32'hDEADBEEF;
        step();
        load_en = 1'b0;

        foreach (vecs[i]) fetch_check(vecs[i].name, vecs[i].pc, vecs[i].instr, vecs[i].err);

        // Back-to-back streaming
        resp_ready = 1'b1;
        hs0 = hs_count; hs_first = -1;
        acc_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            step();
            check("stream_accept", last_accept, 1);
        end
        req_valid = 1'b0;
        repeat (6) step();
        check("stream_count", hs_count - hs0, 8);
        check("stream_first_lat", hs_first - acc_cyc, LAT);
        check("stream_one_per_cycle", hs_last - hs_first, 7);

        // Backpressure: resp_ready low for 4 cycles mid-stream
        hs0 = hs_count; issued = 0; held = '0;
        for (int c = 0; c < 40 && (issued < 8 || exp_q.size() != 0); c++) begin
            req_valid = (issued < 8);
            req_pc = 32'(64 + 4 * issued);
            resp_ready = !(c >= 4 && c < 8);
            #1;
            if (c == 4) held = resp_instr;
            if (c >= 4 && c < 8) begin
                check("bp_valid_held", resp_valid, 1);
                check("bp_instr_stable", resp_instr, held);
                check("bp_req_ready_low", req_ready, 0);
            end
            step();
            if (last_accept) issued++;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        check("bp_count", hs_count - hs0, 8);

        // Flush with three requests in flight
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            step();
        end
        req_pc = 32'd12; resp_ready = 1'b0; flush = 1'b1;
        #1;
        check("flush_blocks_req", req_ready, 0);
        step();
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        hs0 = hs_count;
        repeat (8) step();
        check("flush_no_resp", hs_count - hs0, 0);
        fetch_check("post_flush", 32'd8, 32'hC0DE0002, 2'b00);

        // Same-cycle load and fetch of word 7
        load_en = 1'b1; load_addr = 6'd7; load_data = 32'hAAAA0000;
        step();
        load_en = 1'b0;
        fetch_check("collide_old", 32'd28, 32'hAAAA0000, 2'b00, 1'b1, 6'd7, 32'h12345678);
        fetch_check("collide_new", 32'd28, 32'h12345678, 2'b00);

        // Randomised traffic against the reference model
        repeat (600) begin
            req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       pc = $urandom;
                1:       pc = 32'($urandom_range(0, 55) * 4 + $urandom_range(0, 3));
                default: pc = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            req_pc = pc;
            resp_ready = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 24) == 0);
            load_en = ($urandom_range(0, 5) == 0);
            load_addr = 6'($urandom_range(0, 63));
            load_data = $urandom;
            step();
        end
        flush = 1'b0; load_en = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (10) step();
        check("rand_drained", exp_q.size(), 0);

        // Reset in the middle of a stalled stream
        resp_ready = 1'b0; req_valid = 1'b1;
        req_pc = 32'd40; step();
        req_pc = 32'd44; step();
        req_valid = 1'b0; step();
        check("midrst_pre_valid", resp_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid_dropped", resp_valid, 0);
        check("midrst_instr_zero", resp_instr, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1; resp_ready = 1'b1;
        wait_boot();
        fetch_check("midrst_retained", 32'd40, ref_mem[10], 2'b00);
        fetch_check("midrst_word3", 32'd12, ref_mem[3], 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_pipelined.md
# instr_mem_pipelined

Parametrised, pipelined instruction memory for the fetch stage. Serves byte-addressed 32-bit instruction reads through a valid/ready request/response handshake with configurable read latency, response backpressure and pipeline flush. Provides a word-write load port for program download and reports misaligned and out-of-range fetches. Sits between the PC register and the IF/ID pipeline register.

## Interface
- `ADDR_W`, 32, PC width in bits.
- `DEPTH_WORDS`, 48, number of 32-bit words stored; legal range 2..65536.
- `LATENCY`, 1, cycles from request accept to response valid; legal range 1..4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_pc`  in  ADDR_W  byte address.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_instr`  out  32  instruction word, little-endian byte order.
- `resp_err`  out  2  bit0 misaligned, bit1 out of range.
- `flush`  in  1  discard all in-flight and pending responses.
- `load_en`  in  1  write `load_data` at `load_addr`.
- `load_addr`  in  $clog2(DEPTH_WORDS)  word index.
- `load_data`  in  32  word to write.
- `boot_busy`  out  1  boot preload in progress.

## Operation
- Storage: `DEPTH_WORDS` x 32-bit word array, word index = `req_pc >> 2`.
- Error check at accept: misaligned = `req_pc[1:0] != 0`; out of range = `(req_pc >> 2) >= DEPTH_WORDS`; bits independent. Any error bit set: `resp_instr` = 0.
- Array read at the accept cycle; data and error bits travel down a `LATENCY`-deep valid-tagged shift pipeline.
- Pipeline advances when `!(resp_valid && !resp_ready)`. Stall freezes every stage; no data lost or duplicated.
- `req_ready` = advance && !`flush` && state == RUN.
- `flush`: clears every stage valid and `resp_valid` at the next edge; a request presented in the flush cycle is not accepted.
- Load: word written at the edge when `load_en`; out-of-range `load_addr` ignored. Load and accepted read to the same word in one cycle: the read returns the old word.
- FSM states: BOOT (counter 0..5) -> RUN. BOOT is entered only with the macro; otherwise reset goes directly to RUN. `load_en` is ignored in BOOT.

## Timing
- Reset values: `resp_valid` 0, `resp_instr` 0, `resp_err` 0, all stage valids 0, boot counter 0.
- `req_ready` after reset: 1 in RUN, 0 in BOOT.
- Request accepted at edge N -> `resp_valid` high after edge N+LATENCY-1, i.e. visible in cycle N+LATENCY, absent stall.
- Sustained throughput: one fetch per cycle with `resp_ready` held high.
- Reset asserted mid-operation: all in-flight responses are dropped immediately. Array contents are retained, except that the boot image is rewritten when the macro is defined.

## Configuration
- `IMEM_BOOT_PRELOAD_EN` defined:
  - After reset deasserts, BOOT writes one word per cycle for 6 cycles, with `boot_busy` = 1.
  - Words 0..5: 0x00220000, 0x00640000, 0x00A60000, 0x00E81000, 0x012A1800, 0x016C0000.
  - Then RUN, with `boot_busy` = 0.
- Undefined: no BOOT state. `boot_busy` is tied 0, and array contents are undefined until loaded.

## Structure
- Package `imem_pkg` holds:
  - the boot image constant array and its length (6);
  - error-bit index constants `IMEM_ERR_MISALIGN`, `IMEM_ERR_RANGE`;
  - `LATENCY` bounds.
- One sub-module, `imem_resp_pipe`: parametrised `LATENCY`-deep valid/data/err shift pipeline with a common stall and a synchronous flush clear.

## Test plan
- Boot preload (macro on): release reset -> `boot_busy` high exactly 6 cycles; then fetch PCs 0,4,...,20 -> 0x00220000 ... 0x016C0000 in order.
- Back-to-back streaming, `LATENCY`=3, `resp_ready`=1: 8 consecutive PCs -> 8 responses, first in the 3rd cycle after first accept, one per cycle, correct order.
- Backpressure: drop `resp_ready` for 4 cycles mid-stream -> `resp_instr` held stable, `req_ready` 0, no loss or duplication after release.
- Errors: PC 0x6 -> `resp_err`=01, instr 0. PC 4*DEPTH_WORDS -> `resp_err`=10, instr 0. PC 4*DEPTH_WORDS+2 -> `resp_err`=11.
- Flush with 3 requests in flight -> zero responses emitted. Next request after flush -> normal response at accept+LATENCY.
- Load/read collision: word 7 holds 0xAAAA0000; load 0x12345678 to word 7 in the same cycle as a fetch of PC 28 -> 0xAAAA0000 returned. A later fetch of PC 28 -> 0x12345678.
